// File: rtl/ram_fifo_pkg.sv
// Shared constants and helpers for the RAM-backed first-word-fall-through FIFO.
package ram_fifo_pkg;

  localparam int unsigned DIGEST_W       = 160;
  localparam int unsigned DEF_ADDR       = 9;
  localparam int unsigned DEF_AEMPTY_LVL = 4;
  localparam int unsigned AFULL_MARGIN   = 4;

  // Pointers carry one extra wrap bit beyond the RAM address.
  function automatic int unsigned ptr_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  function automatic int unsigned def_afull_lvl(input int unsigned addr_w);
    return (32'd1 << addr_w) - AFULL_MARGIN;
  endfunction

endpackage

// File: rtl/ram_fifo_if.sv
// Producer/consumer handshake and status bundle for ram_fifo.
interface ram_fifo_if
  import ram_fifo_pkg::*;
#(
  parameter int unsigned DATA = DIGEST_W,
  parameter int unsigned ADDR = DEF_ADDR
);

  logic            clear;
  logic            wr_valid;
  logic            wr_ready;
  logic [DATA-1:0] wr_data;
  logic            rd_valid;
  logic            rd_ready;
  logic [DATA-1:0] rd_data;
  logic [ADDR:0]   count;
  logic            almost_full;
  logic            almost_empty;
  logic            overflow;

  modport master (
    output clear, wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, count, almost_full, almost_empty, overflow
  );

  modport slave (
    input  clear, wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, count, almost_full, almost_empty, overflow
  );

endinterface

// File: rtl/ram_sdp.sv
// Simple dual-port single-clock RAM with registered read port; array is not reset.
module ram_sdp #(
  parameter int unsigned DATA = 160,
  parameter int unsigned ADDR = 9
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [ADDR-1:0] wr_addr,
  input  logic [DATA-1:0] wr_din,
  input  logic            rd_en,
  input  logic [ADDR-1:0] rd_addr,
  output logic [DATA-1:0] rd_dout
);

  localparam int unsigned DEPTH = 1 << ADDR;

  logic [DATA-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_din;
    if (rd_en) rd_dout <= mem[rd_addr];
  end

endmodule

// File: rtl/ram_fifo.sv
// FWFT FIFO: block RAM storage, one prefetch slot (RAM output register) and one
// registered output word, with occupancy, thresholds, flush and sticky overflow.
module ram_fifo
  import ram_fifo_pkg::*;
#(
  parameter int unsigned DATA       = DIGEST_W,
  parameter int unsigned ADDR       = DEF_ADDR,
  parameter int unsigned AFULL_LVL  = def_afull_lvl(ADDR),
  parameter int unsigned AEMPTY_LVL = DEF_AEMPTY_LVL
) (
  input  logic        clk,
  input  logic        rst_n,
  ram_fifo_if.slave   bus
);

  localparam int unsigned PTR_W = ptr_w(ADDR);
  localparam int unsigned DEPTH = 1 << ADDR;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic             rd_valid_q, rd_valid_d;
  logic [DATA-1:0]  rd_data_q, rd_data_d;
  logic             pf_valid_q, pf_valid_d;
  logic             wr_ready_q, wr_ready_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;

  logic             wr_acc, pop, out_free, load_out;
  logic             ram_wr_en, ram_rd_en;
  logic [DATA-1:0]  ram_dout;

  // Next-state: pop/prefetch pipeline, pointers, occupancy and status flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    pf_valid_d = pf_valid_q;
    ovf_d      = ovf_q;
    ram_wr_en  = 1'b0;
    ram_rd_en  = 1'b0;

    wr_acc   = bus.wr_valid && wr_ready_q;
    pop      = rd_valid_q && bus.rd_ready;
    out_free = !rd_valid_q || pop;
    load_out = pf_valid_q && out_free;

    if (bus.clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      rd_valid_d = 1'b0;
      pf_valid_d = 1'b0;
      ovf_d      = 1'b0;
    end else begin
      ram_wr_en = wr_acc;
      // The RAM output register holds an unconsumed prefetch until the output frees.
      ram_rd_en = (wr_ptr_q != rd_ptr_q) && out_free;

      if (wr_acc)    wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (ram_rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      if (wr_acc && !pop)      count_d = count_q + PTR_W'(1);
      else if (!wr_acc && pop) count_d = count_q - PTR_W'(1);

      if (load_out) begin
        rd_valid_d = 1'b1;
        rd_data_d  = ram_dout;
      end else if (pop) begin
        rd_valid_d = 1'b0;
      end

      if (ram_rd_en)     pf_valid_d = 1'b1;
      else if (load_out) pf_valid_d = 1'b0;

      if (bus.wr_valid && !wr_ready_q) ovf_d = 1'b1;
    end

    wr_ready_d = 32'(count_d) < DEPTH;
    afull_d    = 32'(count_d) >= AFULL_LVL;
    aempty_d   = 32'(count_d) <= AEMPTY_LVL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      pf_valid_q <= 1'b0;
      wr_ready_q <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      pf_valid_q <= pf_valid_d;
      wr_ready_q <= wr_ready_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
    end
  end

  ram_sdp #(
    .DATA (DATA),
    .ADDR (ADDR)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr_q[ADDR-1:0]),
    .wr_din  (bus.wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr_q[ADDR-1:0]),
    .rd_dout (ram_dout)
  );

  assign bus.wr_ready     = wr_ready_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.count        = count_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_ram_fifo.sv
// Randomized self-checking bench for ram_fifo against a queue-based reference.
module tb_ram_fifo;

  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AFULL  = 12;
  localparam int unsigned AEMPTY = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_fifo_if #(.DATA(DW), .ADDR(AW)) bus ();

  ram_fifo #(
    .DATA(DW), .ADDR(AW), .AFULL_LVL(AFULL), .AEMPTY_LVL(AEMPTY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] q[$];
  bit ov_m = 1'b0;

  // One clock of stimulus; the reference queue is updated with the spec's accept rules.
  task automatic step(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit clr);
    bit wa, pa;
    @(negedge clk);
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    bus.clear    = clr;
    wa = wv && (q.size() < DEPTH);
    pa = rr && bus.rd_valid;
    @(posedge clk);
    if (clr) begin
      q.delete();
      ov_m = 1'b0;
    end else begin
      if (wv && !wa) ov_m = 1'b1;
      if (pa && q.size() > 0) void'(q.pop_front());
      if (wa) q.push_back(wd);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.clear = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.count !== 5'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    vectors++; if (bus.rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
    vectors++; if (bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready got=%b exp=1", bus.wr_ready); end
    vectors++; if (bus.almost_empty !== 1'b1) begin miscompares++; $display("FAIL reset_aempty got=%b exp=1", bus.almost_empty); end
    vectors++; if (bus.almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_afull got=%b exp=0", bus.almost_full); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_latency();
    step(1'b1, DW'('hA5), 1'b0, 1'b0);
    vectors++; if (bus.count !== 5'd1) begin miscompares++; $display("FAIL lat_count got=%0d exp=1", bus.count); end
    vectors++; if (bus.rd_valid !== 1'b0) begin miscompares++; $display("FAIL lat_n0 got=%b exp=0", bus.rd_valid); end
    step(1'b0, '0, 1'b0, 1'b0);
    vectors++; if (bus.rd_valid !== 1'b0) begin miscompares++; $display("FAIL lat_n1 got=%b exp=0", bus.rd_valid); end
    step(1'b0, '0, 1'b0, 1'b0);
    vectors++; if (bus.rd_valid !== 1'b1) begin miscompares++; $display("FAIL lat_n2 got=%b exp=1", bus.rd_valid); end
    vectors++; if (bus.rd_data !== DW'('hA5)) begin miscompares++; $display("FAIL lat_data got=%0h exp=a5", bus.rd_data); end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      vectors++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== DW'('hA5)) begin
        miscompares++; $display("FAIL lat_hold%0d got=%b/%0h exp=1/a5", i, bus.rd_valid, bus.rd_data); end
    end
    step(1'b0, '0, 1'b1, 1'b0);
    vectors++; if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0) begin
      miscompares++; $display("FAIL lat_pop got=%0d/%b exp=0/0", bus.count, bus.rd_valid); end
  endtask

  task automatic test_fill();
    int exp_v, cyc;
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    vectors++; if (bus.count !== 5'd16) begin miscompares++; $display("FAIL fill_count got=%0d exp=16", bus.count); end
    vectors++; if (bus.wr_ready !== 1'b0) begin miscompares++; $display("FAIL fill_wr_ready got=%b exp=0", bus.wr_ready); end
    vectors++; if (bus.almost_full !== 1'b1) begin miscompares++; $display("FAIL fill_afull got=%b exp=1", bus.almost_full); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL fill_ovf_pre got=%b exp=0", bus.overflow); end
    step(1'b1, DW'(16), 1'b0, 1'b0);
    vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL fill_ovf got=%b exp=1", bus.overflow); end
    vectors++; if (bus.count !== 5'd16) begin miscompares++; $display("FAIL fill_count17 got=%0d exp=16", bus.count); end
    exp_v = 0; cyc = 0;
    while (exp_v < 16 && cyc < 40) begin
      if (bus.rd_valid) begin
        vectors++; if (bus.rd_data !== DW'(exp_v)) begin
          miscompares++; $display("FAIL fill_drain got=%0h exp=%0h", bus.rd_data, exp_v); end
        exp_v++;
      end
      step(1'b0, '0, 1'b1, 1'b0);
      cyc++;
    end
    vectors++; if (exp_v != 16 || cyc != 16) begin
      miscompares++; $display("FAIL fill_drain_rate got=%0d words in %0d cycles exp=16 in 16", exp_v, cyc); end
    vectors++; if (bus.rd_valid !== 1'b0 || bus.count !== 5'd0) begin
      miscompares++; $display("FAIL fill_extra got=%b/%0d exp=0/0", bus.rd_valid, bus.count); end
  endtask

  task automatic test_full_rw();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, DW'(i + 100), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, DW'('hDEAD), 1'b1, 1'b0);
    vectors++; if (bus.count !== 5'd15) begin miscompares++; $display("FAIL frw_count got=%0d exp=15", bus.count); end
    vectors++; if (bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL frw_wr_ready got=%b exp=1", bus.wr_ready); end
    vectors++; if (bus.overflow !== ov_m) begin miscompares++; $display("FAIL frw_ovf got=%b exp=%b", bus.overflow, ov_m); end
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      if (bus.rd_valid) begin
        vectors++; if (bus.rd_data !== q[0]) begin
          miscompares++; $display("FAIL frw_drain got=%0h exp=%0h", bus.rd_data, q[0]); end
      end
      step(1'b0, '0, 1'b1, 1'b0);
    end
    vectors++; if (q.size() != 0 || bus.count !== 5'd0) begin
      miscompares++; $display("FAIL frw_drain_end got=%0d exp=0", bus.count); end
  endtask

  task automatic test_stream();
    int written, idle_run;
    bit wv, rr;
    logic [DW-1:0] wd;
    step(1'b0, '0, 1'b0, 1'b1);
    written = 0; idle_run = 0;
    for (int c = 0; c < 8000 && written < 1000; c++) begin
      wv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      wd = DW'($urandom);
      if (bus.rd_valid) begin
        vectors++; if (q.size() == 0 || bus.rd_data !== q[0]) begin
          miscompares++; $display("FAIL stream_data got=%0h exp=%0h", bus.rd_data, (q.size() > 0) ? q[0] : '0); end
      end
      if (wv && q.size() < DEPTH) written++;
      step(wv, wd, rr, 1'b0);
      vectors++; if (bus.count !== 5'(q.size()) || bus.count > 5'd16) begin
        miscompares++; $display("FAIL stream_count got=%0d exp=%0d", bus.count, q.size()); end
      vectors++; if (bus.wr_ready !== (q.size() < DEPTH) || bus.almost_full !== (q.size() >= AFULL)
                     || bus.almost_empty !== (q.size() <= AEMPTY) || bus.overflow !== ov_m) begin
        miscompares++; $display("FAIL stream_flags got=%b%b%b%b exp=%b%b%b%b", bus.wr_ready, bus.almost_full,
          bus.almost_empty, bus.overflow, q.size() < DEPTH, q.size() >= AFULL, q.size() <= AEMPTY, ov_m); end
      idle_run = (q.size() > 0 && !bus.rd_valid) ? idle_run + 1 : 0;
      vectors++; if (idle_run > 2) begin
        miscompares++; $display("FAIL stream_stall got=%0d idle cycles exp<=2", idle_run); end
    end
    vectors++; if (written != 1000) begin miscompares++; $display("FAIL stream_budget got=%0d exp=1000", written); end
    for (int c = 0; c < 60 && q.size() > 0; c++) begin
      if (bus.rd_valid) begin
        vectors++; if (bus.rd_data !== q[0]) begin
          miscompares++; $display("FAIL stream_drain got=%0h exp=%0h", bus.rd_data, q[0]); end
      end
      step(1'b0, '0, 1'b1, 1'b0);
    end
    vectors++; if (q.size() != 0 || bus.count !== 5'd0) begin
      miscompares++; $display("FAIL stream_drain_end got=%0d exp=0", bus.count); end
  endtask

  task automatic test_clear_reset();
    int lat;
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) step(1'b1, DW'(i + 'h200), 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b0);
    vectors++; if (bus.count !== 5'd7 || bus.rd_valid !== 1'b1 || bus.overflow !== 1'b1) begin
      miscompares++; $display("FAIL clr_pre got=%0d/%b/%b exp=7/1/1", bus.count, bus.rd_valid, bus.overflow); end
    step(1'b1, DW'('h55), 1'b1, 1'b1);
    vectors++; if (bus.count !== 5'd0) begin miscompares++; $display("FAIL clr_count got=%0d exp=0", bus.count); end
    vectors++; if (bus.rd_valid !== 1'b0) begin miscompares++; $display("FAIL clr_rd_valid got=%b exp=0", bus.rd_valid); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL clr_overflow got=%b exp=0", bus.overflow); end
    vectors++; if (bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL clr_wr_ready got=%b exp=1", bus.wr_ready); end
    step(1'b1, DW'('h3C), 1'b0, 1'b0);
    lat = 1;
    while (!bus.rd_valid && lat < 10) begin
      step(1'b0, '0, 1'b0, 1'b0);
      lat++;
    end
    vectors++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== DW'('h3C) || lat != 3) begin
      miscompares++; $display("FAIL clr_first got=%b/%0h after %0d edges exp=1/3c after 3", bus.rd_valid, bus.rd_data, lat); end
    step(1'b1, DW'(1), 1'b0, 1'b0);
    step(1'b1, DW'(2), 1'b1, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
      miscompares++; $display("FAIL arst_out got=%0d/%b/%0h exp=0/0/0", bus.count, bus.rd_valid, bus.rd_data); end
    vectors++; if (bus.wr_ready !== 1'b1 || bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0 || bus.overflow !== 1'b0) begin
      miscompares++; $display("FAIL arst_flags got=%b%b%b%b exp=1100", bus.wr_ready, bus.almost_empty, bus.almost_full, bus.overflow); end
    q.delete();
    ov_m = 1'b0;
    bus.wr_valid = 1'b0; bus.rd_ready = 1'b0; bus.clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, DW'('h77), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    vectors++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== DW'('h77) || bus.count !== 5'd1) begin
      miscompares++; $display("FAIL arst_after got=%b/%0h/%0d exp=1/77/1", bus.rd_valid, bus.rd_data, bus.count); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_full_rw();
    test_stream();
    test_clear_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_fifo.md
Name: ram_fifo

Overview:
- Single-clock, parametrised first-word-fall-through FIFO built on an inferred simple dual-port block RAM.
- Next-generation buffer for the cracker datapath. Queues DATA-bit words, 160-bit SHA1 digests by default, between hash cores and the PMK compare stage.
- Adds valid/ready handshakes, occupancy tracking, thresholds, flush and overflow detection on top of raw RAM storage.

Parameters:
- DATA, 160, word width in bits (>=1).
- ADDR, 9, RAM address width. Storage depth DEPTH = 2**ADDR words.
- AFULL_LVL, 2**ADDR-4, almost_full asserts when count >= AFULL_LVL.
- AEMPTY_LVL, 4, almost_empty asserts when count <= AEMPTY_LVL.

Ports:
- clk, input, 1, sole clock; all logic on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous flush.
- wr_valid, input, 1, write request.
- wr_ready, output, 1, FIFO can accept a word this cycle.
- wr_data, input, DATA, write word.
- rd_valid, output, 1, rd_data holds the head word.
- rd_ready, input, 1, consumer takes the head word.
- rd_data, output, DATA, head word (registered).
- count, output, ADDR+1, occupancy, 0..DEPTH.
- almost_full, output, 1, count >= AFULL_LVL.
- almost_empty, output, 1, count <= AEMPTY_LVL.
- overflow, output, 1, sticky: a write was attempted while wr_ready=0.

Behaviour:
- Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0, rd_valid=0, rd_data=0, wr_ready=1, almost_full=0, almost_empty=1, overflow=0. RAM contents are not reset.
- Pointers are ADDR+1 bits; the MSB distinguishes wrap. RAM is addressed by ptr[ADDR-1:0]; pointer increments wrap modulo 2**(ADDR+1).
- Write accept: wr_valid & wr_ready. The word is written to RAM at wr_ptr and wr_ptr increments at that edge.
- wr_ready = (count < DEPTH), derived from registered count only. A same-cycle read does not free a slot for a write.
- Read accept: rd_valid & rd_ready. The head entry is popped at that edge.
- Output stage: one DATA-bit register. It counts toward count; count covers RAM entries, entries in flight to the output register, and the output register itself.
- Prefetch: when the output register is empty or being popped, and RAM holds unread data, issue the RAM read at rd_ptr and increment rd_ptr. The registered RAM output loads rd_data one edge later; rd_valid rises with it.
- Latency: a write accepted at edge N into an empty FIFO gives rd_valid=1 after edge N+2. This fixed two-cycle latency applies whenever the FIFO is empty at edge N.
- Throughput: sustained 1 word/cycle in and out once primed. A pop never leaves a bubble if data is in RAM; the pipeline holds at most one prefetch in flight.
- rd_data is stable while rd_valid=1 and rd_ready=0.
- count update: +1 on write accept only, -1 on read accept only, unchanged on both or neither.
- almost_full and almost_empty are registered, computed from next count, so they are coincident with count.
- overflow: set when wr_valid=1 and wr_ready=0; the write is dropped. Cleared only by reset or clear.
- clear (sync, highest priority): pointers=0, count=0, rd_valid=0, overflow=0, wr_ready=1. Write/read accepts in the same cycle are ignored, and any in-flight prefetch is discarded.
- Reading while empty (rd_ready with rd_valid=0): no effect.
- Full and simultaneous read: the read is accepted, count goes to DEPTH-1, and wr_ready=1 on the next cycle.
- RAM read-during-write to the same address cannot occur, because prefetch only reads entries already written in earlier cycles. The memory needs no bypass.

Decomposition:
- Shared package holds:
  - the pointer-width function ADDR+1;
  - the default DIGEST width 160;
  - threshold defaults.
- One sub-module, ram_sdp: an inferred simple dual-port, single-clock RAM with parameters DATA and ADDR.
  - Ports: clk, wr_en, wr_addr, wr_din, rd_en, rd_addr, rd_dout.
  - Registered read output, no reset on the array.
- Control, pointers, count and output stage stay in ram_fifo.

Test Plan:
- Reset then idle: after rst_n deasserts, check count=0, rd_valid=0, wr_ready=1, almost_empty=1, overflow=0.
- Latency: with ADDR=4, write 0xA5 at edge N into an empty FIFO. rd_valid=1 with rd_data=0xA5 after edge N+2; hold rd_ready=0 for 5 cycles and rd_data stays 0xA5.
- Fill to full: with ADDR=4, write 16 words 0..15 without reading. count=16, wr_ready=0, almost_full=1. A 17th wr_valid sets overflow=1; then drain and check data is 0..15 in order, with no 16.
- Streaming with backpressure: 1000 random words, random wr_valid/rd_ready at 50%. Output order matches a reference queue, count never exceeds 16, and there are no lost or duplicated words across pointer wrap.
- Simultaneous read/write at full: at count=16, assert wr_valid and rd_ready together. The read is accepted, the write is refused, and count=15 next cycle.
- Clear and async reset mid-stream: at count=7 with a prefetch in flight, pulse clear with wr_valid=1. Next cycle count=0, rd_valid=0, overflow=0, and the next written word 0x3C is the first word read. Repeat with rst_n asserted mid-cycle: outputs go to reset values immediately, without waiting for a clock edge.
